// File: rtl/vec_pipe_reg.sv
// vec_pipe_reg: lane-masked elastic pipeline register with valid/ready handshake and flush.
// Ports: clk, reset (async, active-high), flush (sync drop of all entries),
//   in_valid/in_ready/in_data/in_mask (upstream, masked-off lanes repeat last written value),
//   out_valid/out_ready/out_data (downstream, head entry, register-driven).
// Build option: define VEC_PIPE_REG_SKID_EN for a two-entry skid buffer with registered in_ready.
module vec_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data
);
  logic [LANES*WIDTH-1:0] s, s_n;
  logic acc, pop;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  // Shadow merged with the written lanes; this is also the value that gets enqueued.
  always_comb begin
    s_n = s;
    for (int i = 0; i < LANES; i++)
      if (in_mask[i]) s_n[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) s <= '0;
    else if (acc) s <= s_n;
`ifdef VEC_PIPE_REG_SKID_EN
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0] st, st_n;
  logic rdy;
  logic [LANES*WIDTH-1:0] skid;
  always_comb
    st_n = flush ? EMPTY :
           st == EMPTY ? (acc ? ONE : EMPTY) :
           st == ONE ? (acc && !pop ? FULL : !acc && pop ? EMPTY : ONE) :
           (pop ? ONE : FULL);
  assign out_valid = st != EMPTY;
  // Registered readiness keeps out_ready off the in_ready path; flush only gates it.
  assign in_ready = rdy && !flush;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= EMPTY;
      rdy <= 1'b1;
      out_data <= '0;
      skid <= '0;
    end else begin
      st <= st_n;
      rdy <= st_n != FULL;
      if (st == FULL && pop) out_data <= skid;
      else if (acc && (st == EMPTY || pop)) out_data <= s_n;
      if (acc && st == ONE && !pop) skid <= s_n;
    end
`else
  assign in_ready = (!out_valid || out_ready) && !flush;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= flush ? 1'b0 : acc ? 1'b1 : pop ? 1'b0 : out_valid;
      if (acc) out_data <= s_n;
    end
`endif
endmodule

// File: tb/tb_vec_pipe_reg.sv
// tb_vec_pipe_reg: directed and random checks of vec_pipe_reg against a queue-based model.
module tb_vec_pipe_reg;
  localparam int W = 32, L = 4, DW = W * L;
`ifdef VEC_PIPE_REG_SKID_EN
  localparam int CAP = 2;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP = 1;
  localparam bit SKID = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [L-1:0] in_mask;
  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] sh;
  always #5 clk = ~clk;
  vec_pipe_reg #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction
  // One clock cycle: drive, check against the model, advance model on the edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [L-1:0] m,
                     input logic ordy, input logic fl, output logic accepted);
    logic exp_rdy, exp_pop;
    logic [DW-1:0] nxt;
    in_valid = v; in_data = d; in_mask = m; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (q.size() < CAP || (!SKID && ordy));
    chk("in_ready", DW'(in_ready), DW'(exp_rdy));
    chk("out_valid", DW'(out_valid), DW'(q.size() != 0));
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    accepted = v && exp_rdy;
    exp_pop = q.size() != 0 && ordy;
    nxt = sh;
    for (int i = 0; i < L; i++) if (m[i]) nxt[i*W +: W] = d[i*W +: W];
    @(posedge clk);
    if (exp_pop) void'(q.pop_front());
    if (fl) q.delete();
    if (accepted) begin
      sh = nxt;
      q.push_back(nxt);
    end
    @(negedge clk);
  endtask
  initial begin
    logic a, pv;
    logic [DW-1:0] w[3], x, y, pd;
    logic [L-1:0] pm;
    int idx;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b0;
    sh = '0;
    #2;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, {L{32'h11111111}}, '1, 1'b1, 1'b0, a);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, a);
    cyc(1'b1, {32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111, 1'b1, 1'b0, a);
    cyc(1'b1, {32'hD, 32'hC, 32'hB, 32'hA}, 4'b0101, 1'b1, 1'b0, a);
    chk("mask_merge", out_data, {32'h4, 32'hC, 32'h2, 32'hA});
    cyc(1'b0, '0, '0, 1'b1, 1'b0, a);
    for (int i = 0; i < 3; i++) w[i] = rnd();
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(idx < 3, w[idx % 3], '1, 1'b0, 1'b0, a);
      if (a) idx++;
    end
    chk("bp_accepted", DW'(idx), DW'(CAP));
    for (int k = 0; k < 8; k++) begin
      cyc(idx < 3, w[idx % 3], '1, 1'b1, 1'b0, a);
      if (a) idx++;
    end
    chk("bp_total", DW'(idx), DW'(3));
    for (int k = 0; k < CAP + 1; k++) cyc(1'b1, rnd(), '1, 1'b0, 1'b0, a);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, a);
    cyc(1'b1, rnd(), 4'b0000, 1'b0, 1'b0, a);
    chk("flush_keeps_s", out_data, sh);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, a);
    x = rnd(); y = rnd();
    cyc(1'b1, x, '1, 1'b0, 1'b0, a);
    cyc(1'b1, y, '1, 1'b1, 1'b0, a);
    chk("one_acc_pop_data", out_data, y);
    chk("one_acc_pop_count", DW'(q.size()), DW'(1));
    pv = 1'b0; pd = '0; pm = '0;
    for (int k = 0; k < 300; k++) begin
      if (!pv && $urandom_range(9) < 7) begin
        pv = 1'b1; pd = rnd(); pm = L'($urandom);
      end
      cyc(pv, pd, pm, 1'($urandom), $urandom_range(19) == 0, a);
      if (a) pv = 1'b0;
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, '0, 1'b1, 1'b0, a);
    cyc(1'b1, rnd(), '1, 1'b0, 1'b0, a);
    in_valid = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", DW'(out_valid), '0);
    chk("mid_rst_out_data", out_data, '0);
    chk("mid_rst_in_ready", DW'(in_ready), DW'(1));
    q.delete();
    sh = '0;
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, {L{32'h11111111}}, '1, 1'b1, 1'b0, a);
    chk("post_rst_word", out_data, {L{32'h11111111}});
    cyc(1'b0, '0, '0, 1'b1, 1'b0, a);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
